// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module      : ram_arbiter
//  Description : Two-port round-robin arbiter and access sequencer for a
//                256x16 data RAM with edge-triggered cs/we/re strobes.
//                Each access takes four cycles. Address and data are set up
//                one cycle before the strobe and held one cycle after it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // Port A (CPU core)
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    // Port B (DMA / peripheral engine)
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_re,
    // Status
    output logic              busy,
    output logic              grant_b
);

    // The state register advances one edge ahead of the registered outputs.
    // Leaving IDLE latches the request. Leaving SETUP raises cs. Leaving
    // STROBE raises the strobe. Leaving DONE drops the strobe and pulses ack.
    // The following IDLE edge drops cs. That edge can also accept the next
    // grant, so the sustained rate is one access every four cycles.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic                last_b_q;
    logic                grant_b_q;
    logic                lat_wr_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_data_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_data_q;
    logic                ram_cs_q;
    logic                ram_we_q;
    logic                ram_re_q;
    logic                busy_q;
    logic                a_ack_q;
    logic                b_ack_q;
    logic [DATA_W-1:0]   a_rdata_q;
    logic [DATA_W-1:0]   b_rdata_q;

    // Round-robin choice. B wins if it is the only requester, or on a tie
    // when A owned the previous transaction.
    logic grant_b_d;
    assign grant_b_d = b_req && (!a_req || !last_b_q);

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_b_q   <= 1'b1;
            grant_b_q  <= 1'b0;
            lat_wr_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_re_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (a_req || b_req) begin
                        grant_b_q  <= grant_b_d;
                        lat_wr_q   <= grant_b_d ? b_wr    : a_wr;
                        lat_addr_q <= grant_b_d ? b_addr  : a_addr;
                        lat_data_q <= grant_b_d ? b_wdata : a_wdata;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    ram_addr_q <= lat_addr_q;
                    ram_data_q <= lat_data_q;
                    ram_cs_q   <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= S_STROBE;
                end
                S_STROBE: begin
                    ram_we_q <= lat_wr_q;
                    ram_re_q <= !lat_wr_q;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    // ram_q has had a full cycle since the read strobe rose
                    ram_we_q <= 1'b0;
                    ram_re_q <= 1'b0;
                    if (grant_b_q) begin
                        b_ack_q <= 1'b1;
                        if (!lat_wr_q) begin
                            b_rdata_q <= ram_q;
                        end
                    end else begin
                        a_ack_q <= 1'b1;
                        if (!lat_wr_q) begin
                            a_rdata_q <= ram_q;
                        end
                    end
                    last_b_q <= grant_b_q;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_cs   = ram_cs_q;
    assign ram_we   = ram_we_q;
    assign ram_re   = ram_re_q;
    assign busy     = busy_q;
    assign grant_b  = grant_b_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed bench for ram_arbiter. It includes a behavioural
//                edge-triggered RAM and a transaction scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_wr, b_req, b_wr;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;
    logic [15:0] ram_q = 16'h0000;
    logic        ram_cs, ram_we, ram_re;
    logic        busy, grant_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_re(ram_re),
        .busy(busy), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: captures on the rising edge of we, updates q on the rising edge of re
    logic [15:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    always @(posedge ram_we) mem[ram_addr] = ram_data;
    always @(posedge ram_re) ram_q = mem[ram_addr];

    typedef struct {
        bit          port_b;
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit pb, input bit wr, input logic [7:0] ad, input logic [15:0] d);
        exp_t e;
        e.port_b = pb; e.wr = wr; e.addr = ad; e.data = d;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait, with a cycle bound, for an ack on the given port
    task automatic wait_ack(input bit pb, output int at);
        at = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pb ? b_ack : a_ack) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL ack_timeout: observed no ack expected ack on port %0d", pb);
        end
    endtask

    // Bus protocol and scoreboard monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("strobe_excl", {31'd0, ram_we & ram_re}, 32'd0);
            check("strobe_wo_cs", {31'd0, (ram_we | ram_re) & ~ram_cs}, 32'd0);
            if (ram_we | ram_re) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL sb_strobe: observed strobe expected none queued");
                end else begin
                    check("sb_dir", {31'd0, ram_we}, {31'd0, sb[0].wr});
                    check("sb_addr", {24'd0, ram_addr}, {24'd0, sb[0].addr});
                    if (sb[0].wr) check("sb_wdata", {16'd0, ram_data}, {16'd0, sb[0].data});
                end
            end
            if (a_ack | b_ack) begin
                check("ack_both", {31'd0, a_ack & b_ack}, 32'd0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL sb_ack: observed ack expected none queued");
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_port", {31'd0, b_ack}, {31'd0, mon_e.port_b});
                    if (!mon_e.wr)
                        check("sb_rdata", {16'd0, mon_e.port_b ? b_rdata : a_rdata},
                              {16'd0, mon_e.data});
                end
            end
        end
    end

    initial begin
        int t, t_prev;
        rst_n = 1'b0;
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        t = 0; t_prev = 0;
        step(2);

        // Reset values
        check("rst_cs", {31'd0, ram_cs}, 0);
        check("rst_we", {31'd0, ram_we}, 0);
        check("rst_re", {31'd0, ram_re}, 0);
        check("rst_a_ack", {31'd0, a_ack}, 0);
        check("rst_b_ack", {31'd0, b_ack}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_grant_b", {31'd0, grant_b}, 0);
        check("rst_addr", {24'd0, ram_addr}, 0);
        check("rst_data", {16'd0, ram_data}, 0);
        check("rst_a_rdata", {16'd0, a_rdata}, 0);
        check("rst_b_rdata", {16'd0, b_rdata}, 0);
        rst_n = 1'b1;
        step(1);
        check("busy_after_rst", {31'd0, busy}, 0);

        // Port A write 16'hBEEF to 8'h30, cycle by cycle
        a_wr = 1; a_addr = 8'h30; a_wdata = 16'hBEEF; a_req = 1;
        push(0, 1, 8'h30, 16'hBEEF);
        step(1);
        check("aw_N_cs", {31'd0, ram_cs}, 0);
        step(1);
        check("aw_N1_cs", {31'd0, ram_cs}, 1);
        check("aw_N1_we", {31'd0, ram_we}, 0);
        check("aw_N1_busy", {31'd0, busy}, 1);
        step(1);
        check("aw_N2_we", {31'd0, ram_we}, 1);
        check("aw_N2_re", {31'd0, ram_re}, 0);
        check("aw_N2_addr", {24'd0, ram_addr}, 32'h30);
        check("aw_N2_data", {16'd0, ram_data}, 32'hBEEF);
        step(1);
        check("aw_N3_ack", {31'd0, a_ack}, 1);
        check("aw_N3_we", {31'd0, ram_we}, 0);
        check("aw_N3_cs", {31'd0, ram_cs}, 1);
        check("aw_N3_grant", {31'd0, grant_b}, 0);
        a_req = 0;
        step(1);
        check("aw_N4_ack", {31'd0, a_ack}, 0);
        check("aw_N4_cs", {31'd0, ram_cs}, 0);
        check("aw_N4_re", {31'd0, ram_re}, 0);
        check("aw_N4_busy", {31'd0, busy}, 0);

        // Port B read of 8'h30
        b_wr = 0; b_addr = 8'h30; b_req = 1;
        push(1, 0, 8'h30, 16'hBEEF);
        step(3);
        check("br_N2_re", {31'd0, ram_re}, 1);
        check("br_N2_grant", {31'd0, grant_b}, 1);
        check("br_N2_ack", {31'd0, b_ack}, 0);
        step(1);
        check("br_N3_ack", {31'd0, b_ack}, 1);
        check("br_N3_rdata", {16'd0, b_rdata}, 32'hBEEF);
        check("br_N3_a_ack", {31'd0, a_ack}, 0);
        b_req = 0;
        step(2);

        // Simultaneous continuous requests straight after reset: A, B, A, B
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        a_wr = 1; a_addr = 8'h40; a_wdata = 16'hA5A5; a_req = 1;
        b_wr = 0; b_addr = 8'h40; b_req = 1;
        push(0, 1, 8'h40, 16'hA5A5);
        push(1, 0, 8'h40, 16'hA5A5);
        push(0, 1, 8'h40, 16'hA5A5);
        push(1, 0, 8'h40, 16'hA5A5);
        for (int i = 0; i < 4; i++) begin
            wait_ack(i[0], t);
            if (i > 0) check("ack_spacing", t - t_prev, 32'd4);
            t_prev = t;
        end
        a_req = 0; b_req = 0;
        step(4);
        check("sb_drained", sb.size(), 32'd0);

        // Requester drops early: the write still completes
        a_wr = 1; a_addr = 8'h55; a_wdata = 16'h1234; a_req = 1;
        push(0, 1, 8'h55, 16'h1234);
        step(1);
        a_req = 0;
        step(2);
        check("drop_N2_we", {31'd0, ram_we}, 1);
        step(1);
        check("drop_N3_ack", {31'd0, a_ack}, 1);
        step(2);

        // Reset asserted during STROBE of an A read
        a_wr = 0; a_addr = 8'h55; a_req = 1;
        push(0, 0, 8'h55, 16'h1234);
        step(3);
        check("mid_re_before", {31'd0, ram_re}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_re_async", {31'd0, ram_re}, 0);
        check("mid_we_async", {31'd0, ram_we}, 0);
        check("mid_cs_async", {31'd0, ram_cs}, 0);
        a_req = 0;
        sb.delete();
        step(2);
        rst_n = 1'b1;
        step(2);
        check("mid_no_a_ack", {31'd0, a_ack}, 0);
        check("mid_no_b_ack", {31'd0, b_ack}, 0);

        // Fresh request after reset completes normally
        a_req = 1;
        push(0, 0, 8'h55, 16'h1234);
        wait_ack(0, t);
        a_req = 0;
        check("fresh_rdata", {16'd0, a_rdata}, 32'h1234);
        step(3);
        check("final_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
